// File: rtl/plic_lite_pkg.sv
// rtl/plic_lite_pkg.sv - plic_lite register map, ID constants and address decode helper
package plic_lite_pkg;

   localparam logic [7:0] PLIC_PENDING = 8'h00;
   localparam logic [7:0] PLIC_ENABLE  = 8'h04;
   localparam logic [7:0] PLIC_TRIGGER = 8'h08;
   localparam logic [7:0] PLIC_CLAIM   = 8'h0C;

   localparam int PLIC_ID_W = 5;
   localparam logic [PLIC_ID_W-1:0] PLIC_ID_NONE = '0;

   typedef enum logic [1:0] {
      REG_PENDING,
      REG_ENABLE,
      REG_TRIGGER,
      REG_CLAIM
   } reg_sel_e;

   typedef struct packed {
      logic     hit;
      reg_sel_e sel;
   } reg_dec_t;

   // Word-aligned decode; bits [1:0] of the byte offset are ignored.
   function automatic reg_dec_t decode_addr(input logic [7:0] address);
      reg_dec_t dec;
      dec.hit = 1'b1;
      dec.sel = REG_PENDING;
      case ({address[7:2], 2'b00})
         PLIC_PENDING: dec.sel = REG_PENDING;
         PLIC_ENABLE:  dec.sel = REG_ENABLE;
         PLIC_TRIGGER: dec.sel = REG_TRIGGER;
         PLIC_CLAIM:   dec.sel = REG_CLAIM;
         default:      dec.hit = 1'b0;
      endcase
      return dec;
   endfunction

endpackage

// File: rtl/plic_lite_gateway.sv
// rtl/plic_lite_gateway.sv - per-source synchroniser, edge detect, pending and in-flight state
module plic_gateway
   import plic_lite_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic src,
   input  logic trigger,
   input  logic claim,
   input  logic complete,
   output logic pending,
   output logic in_flight
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   src_s;
   logic                   src_prev;
   logic                   rise;

   assign src_s = sync_q[SYNC_STAGES-1];
   assign rise  = src_s & ~src_prev;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], src};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         src_prev  <= 1'b0;
         pending   <= 1'b0;
         in_flight <= 1'b0;
      end else begin
         src_prev <= src_s;
         // Edge mode: a rise coinciding with the claim-clear keeps pending set.
         if (trigger) begin
            if (rise) begin
               pending <= 1'b1;
            end else if (claim) begin
               pending <= 1'b0;
            end
         end else begin
            pending <= src_s & ~in_flight & ~claim;
         end
         if (claim) begin
            in_flight <= 1'b1;
         end else if (complete) begin
            in_flight <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/plic_lite.sv
// rtl/plic_lite.sv - platform interrupt controller top: registers, priority claim, irq flop
module plic_lite
   import plic_lite_pkg::*;
#(
   parameter int NUM_SRC     = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ren,
   input  logic               wen,
   input  logic [7:0]         address,
   input  logic [31:0]        data_in,
   output logic [31:0]        data_out,
   input  logic [NUM_SRC-1:0] src,
   output logic               irq
);

   logic [NUM_SRC-1:0]   enable;
   logic [NUM_SRC-1:0]   trigger;
   logic [NUM_SRC-1:0]   pending;
   logic [NUM_SRC-1:0]   in_flight;
   logic [NUM_SRC-1:0]   cand;
   logic [NUM_SRC-1:0]   claim_vec;
   logic [NUM_SRC-1:0]   complete_vec;
   logic                 ren_d;
   logic                 found;
   logic [PLIC_ID_W-1:0] win;
   logic [PLIC_ID_W-1:0] claim_id;
   logic                 is_claim;
   logic                 claim_fire;
   logic [31:0]          rdata;
   reg_dec_t             dec;
   logic                 unused_bits;

   assign unused_bits = ^{data_in, address[1:0]};
   assign dec         = decode_addr(address);
   assign is_claim    = dec.hit && (dec.sel == REG_CLAIM);
   assign cand        = pending & enable & ~in_flight;
   assign claim_fire  = ren & ~ren_d & is_claim & found;
   assign claim_id    = found ? win + PLIC_ID_W'(1) : PLIC_ID_NONE;

   // Fixed priority: lowest index wins.
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (cand[i]) begin
            found = 1'b1;
            win   = PLIC_ID_W'(i);
         end
      end
   end

   always_comb begin
      claim_vec    = '0;
      complete_vec = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         claim_vec[i]    = claim_fire && (win == PLIC_ID_W'(i));
         complete_vec[i] = wen && is_claim && (data_in[PLIC_ID_W-1:0] == PLIC_ID_W'(i + 1));
      end
   end

   always_comb begin
      rdata = '0;
      if (dec.hit) begin
         case (dec.sel)
            REG_PENDING: rdata = 32'(pending);
            REG_ENABLE:  rdata = 32'(enable);
            REG_TRIGGER: rdata = 32'(trigger);
            REG_CLAIM:   rdata = 32'(claim_id);
            default:     rdata = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         enable   <= '0;
         trigger  <= '0;
         ren_d    <= 1'b0;
         data_out <= '0;
         irq      <= 1'b0;
      end else begin
         ren_d <= ren;
         irq   <= |cand;
         // A held claim read keeps the ID it claimed instead of re-arbitrating.
         if (ren && !(is_claim && ren_d)) begin
            data_out <= rdata;
         end
         if (wen && dec.hit && dec.sel == REG_ENABLE) begin
            enable <= data_in[NUM_SRC-1:0];
         end
         if (wen && dec.hit && dec.sel == REG_TRIGGER) begin
            trigger <= data_in[NUM_SRC-1:0];
         end
      end
   end

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_gw
      plic_gateway #(
         .SYNC_STAGES(SYNC_STAGES)
      ) u_gw (
         .clk       (clk),
         .reset     (reset),
         .src       (src[g]),
         .trigger   (trigger[g]),
         .claim     (claim_vec[g]),
         .complete  (complete_vec[g]),
         .pending   (pending[g]),
         .in_flight (in_flight[g])
      );
   end

endmodule

// File: doc/plic_lite.md
Name: plic_lite

Overview:
- Small platform-level interrupt controller that drives the CPU `external_interrupt` input, which is currently tied to 0.
- Collects asynchronous peripheral event lines (button presses, UART RX-ready, flash-done, and similar).
- Synchronises and gates each line, then presents a single level interrupt to the CPU.
- Software uses a claim/complete register handshake, memory-mapped on the data bus next to the CLINT.

Parameters:
- NUM_SRC, 8, number of interrupt sources; legal range 1..31. Source i has ID i+1, and ID 0 means "none".
- SYNC_STAGES, 2, flip-flop depth of the input synchroniser per source; minimum 2.

Ports:
- clk  in  1  CPU clock (cpu_clk domain).
- reset  in  1  asynchronous, active-high; clears all state.
- ren  in  1  read strobe from the bus decoder.
- wen  in  1  write strobe from the bus decoder.
- address  in  8  byte offset, data_addr[7:0]; word-aligned, bits [1:0] ignored.
- data_in  in  32  write data.
- data_out  out  32  registered read data.
- src  in  NUM_SRC  raw asynchronous interrupt request lines, active-high.
- irq  out  1  registered external-interrupt request to the CPU.

Behaviour:
- Reset: all state is cleared at once, asynchronously.
  - Cleared: synchroniser flops, src_prev, pending, enable, trigger, in_flight, ren_d.
  - data_out=0 and irq=0 while reset is asserted and on the first clock after release.
- Synchroniser: src_s is src delayed by SYNC_STAGES flops. Edge detection is rise = src_s & ~src_prev, with src_prev = src_s registered one cycle.
- Register map (32-bit words; unused bits read 0 and are ignored on write):
  - 0x00 PENDING (RO): pending[NUM_SRC-1:0].
  - 0x04 ENABLE (RW): enable mask.
  - 0x08 TRIGGER (RW): per source, 1 = rising-edge, 0 = level.
  - 0x0C CLAIM/COMPLETE: read = claim, write = complete.
  - Any other offset: reads 0, writes ignored.
- Read latency: data_out updates on the clock edge where ren=1 and holds its value until the next read. The bus samples it one cycle after ren.
- Claim side effect:
  - Fires only on a rising ren: ren & ~ren_d, where ren_d is ren registered.
  - Holding ren for several cycles therefore claims once.
- Claim selection:
  - cand = pending & enable & ~in_flight.
  - Winner is the lowest set index i (fixed priority, source 0 highest).
  - The read returns i+1 and, in the same edge, clears pending[i] and sets in_flight[i].
  - If cand=0, the read returns 0 and has no side effect.
- Complete: write to 0x0C with data_in[4:0]=id.
  - If 1<=id<=NUM_SRC and in_flight[id-1]=1, in_flight[id-1] is cleared.
  - Otherwise the write is ignored; there is no error.
- Gateway, edge mode (trigger=1):
  - rise sets pending. A rise when pending is already 1 is merged (no counting).
  - pending may set while in_flight=1; it becomes claimable after complete.
  - Same cycle, same source, rise and claim-clear: the set wins and pending stays 1.
- Gateway, level mode (trigger=0):
  - pending <= src_s whenever in_flight=0.
  - While in_flight=1, pending is held 0.
  - After complete, a still-high line re-pends on the next cycle.
- ENABLE masking: clearing an enable bit masks the source but does not clear its pending bit.
- Changing TRIGGER: the new mode takes effect on the next cycle; pending is retained.
- Simultaneous claim and complete writes: impossible from the single-port bus, so no handling is required. A register write and a gateway update on the same cycle use the newly written enable/trigger from the next cycle onward.
- irq: registered, irq <= |(pending & enable & ~in_flight).
  - Typical latency from a src rise to irq=1: SYNC_STAGES+2 clocks (synchroniser, then pending, then irq).
  - irq drops one clock after the claim edge when no other candidate remains.
- Reset asserted mid-handshake: in_flight and pending are dropped, and the CPU restarts with no outstanding claim.

Decomposition:
- Shared package holds:
  - register offsets: PLIC_PENDING=0x00, PLIC_ENABLE=0x04, PLIC_TRIGGER=0x08, PLIC_CLAIM=0x0C;
  - PLIC_ID_W=5;
  - the `none` ID = 0.
- One natural sub-module, plic_gateway: per-source synchroniser, edge detect, pending and in_flight, instantiated NUM_SRC times via generate.
- The top level holds the registers, priority encoder, bus decode and irq flop.

Test Plan:
1. Reset mid-operation: enable=0x01, trigger=0x01, pulse src[0] to get pending=1, then assert reset -> pending=0, in_flight=0, irq=0, data_out=0 immediately; CLAIM after release returns 0.
2. Edge source: enable=0x01, trigger=0x01, pulse src[0] high for 3 clocks -> irq=1 after SYNC_STAGES+2 clocks.
   - CLAIM read returns 1, PENDING reads 0, irq=0 one clock later.
   - Write 1 to 0x0C -> in_flight cleared.
3. Priority: enable=0x0C, trigger=0x0C, pulse src[2] and src[3] in the same cycle.
   - First CLAIM returns 3, second returns 4, third returns 0.
   - irq=0 after the second claim.
4. Level re-assert: trigger=0, enable=0x02, hold src[1]=1 -> CLAIM returns 2.
   - PENDING stays 0 and irq stays 0 while in flight.
   - After complete(2), irq=1 again within 2 clocks; drop src[1] and complete -> irq stays 0.
5. Edge during service: trigger=1, enable=0x01, claim source 1, then pulse src[0] again -> PENDING=0x1 and irq=0.
   - After complete(1), irq=1 and CLAIM returns 1.
6. Illegal and hold cases:
   - complete(0), complete(9) and complete(2) with no claim outstanding -> no state change.
   - ren held for 4 cycles with one candidate -> exactly one claim; pending for the second source is untouched.
